// File: rtl/vector_writeback_unit.sv
// Vector register file write-side front end: ALU results and per-lane load gathers
// share a small FIFO drained one write per cycle. `VWB_BYPASS_EN enables zero-latency ALU bypass.
module vector_writeback_unit #(
  parameter int THREADS = 4,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         nRST,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [4:0]                   alu_wsel,
  input  logic [THREADS-1:0]           alu_wen,
  input  logic [THREADS-1:0][31:0]     alu_wdata,
  input  logic                         ld_start,
  input  logic [4:0]                   ld_wsel,
  input  logic [THREADS-1:0]           ld_mask,
  output logic                         ld_busy,
  input  logic                         lane_valid,
  input  logic [$clog2(THREADS)-1:0]   lane_id,
  input  logic [31:0]                  lane_data,
  input  logic                         wb_stall,
  output logic [4:0]                   wsel,
  output logic [THREADS-1:0]           wen,
  output logic [THREADS-1:0][31:0]     wdata,
  output logic [31:0]                  busy_regs,
  output logic                         lane_err
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [THREADS-1:0][31:0] vec_t;
  typedef enum logic [1:0] {IDLE, GATHER, PUSH} state_t;

  state_t state, state_next;

  logic [4:0]         fifo_wsel [DEPTH];
  logic [THREADS-1:0] fifo_wen  [DEPTH];
  vec_t               fifo_data [DEPTH];
  logic [DEPTH-1:0]   fifo_vld;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;
  logic               full, empty;

  logic [4:0]         ld_sel_q;
  logic [THREADS-1:0] ld_mask_q, recv_q, recv_next, lane_bit;
  vec_t               ld_data_q;

  logic ld_take, ld_push, lane_accept, lane_reject, lane_in_range;
  logic alu_fire, alu_keep, alu_push, bypass, push, pop;
  logic [4:0]         push_wsel;
  logic [THREADS-1:0] push_wen;
  vec_t               push_data;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign ld_busy = (state != IDLE);

  // Classify the incoming lane beat; anything not a fresh expected lane is a protocol error.
  always_comb begin
    lane_in_range = (int'(lane_id) < THREADS);
    lane_bit      = '0;
    if (lane_in_range) lane_bit[lane_id] = 1'b1;
    lane_accept = lane_valid && (state == GATHER) && |(lane_bit & ld_mask_q & ~recv_q);
    lane_reject = lane_valid && !lane_accept;
    recv_next   = recv_q | (lane_accept ? lane_bit : '0);
    ld_take     = (state == IDLE) && ld_start && (ld_mask != '0) && (ld_wsel != '0);
  end

  always_comb begin
    state_next = state;
    ld_push    = 1'b0;
    case (state)
      IDLE:    if (ld_take) state_next = GATHER;
      GATHER:  if (recv_next == ld_mask_q) state_next = PUSH;
      PUSH: begin
        if (!full) begin
          ld_push    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state     <= IDLE;
      ld_sel_q  <= '0;
      ld_mask_q <= '0;
      recv_q    <= '0;
      ld_data_q <= '0;
      lane_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (ld_take) begin
        ld_sel_q  <= ld_wsel;
        ld_mask_q <= ld_mask;
        recv_q    <= '0;
        ld_data_q <= '0;
      end else if (lane_accept) begin
        recv_q             <= recv_next;
        ld_data_q[lane_id] <= lane_data;
      end
      if (lane_reject) lane_err <= 1'b1;
    end
  end

  // Load has priority; alu_ready already excludes PUSH so both never enqueue together.
  always_comb begin
    alu_ready = !full && (state != PUSH);
    alu_fire  = alu_valid && alu_ready;
    alu_keep  = alu_fire && (alu_wsel != '0) && (alu_wen != '0);
`ifdef VWB_BYPASS_EN
    bypass    = alu_keep && empty && !wb_stall;
`else
    bypass    = 1'b0;
`endif
    alu_push  = alu_keep && !bypass;
    push      = ld_push || alu_push;
    pop       = !empty && !wb_stall;
    push_wsel = ld_push ? ld_sel_q  : alu_wsel;
    push_wen  = ld_push ? ld_mask_q : alu_wen;
    push_data = ld_push ? ld_data_q : alu_wdata;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr           <= wr_ptr + PW'(1);
        fifo_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr           <= rd_ptr + PW'(1);
        fifo_vld[rd_ptr] <= 1'b0;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wsel[wr_ptr] <= push_wsel;
      fifo_wen[wr_ptr]  <= push_wen;
      fifo_data[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    wsel  = '0;
    wen   = '0;
    wdata = '0;
    if (pop) begin
      wsel  = fifo_wsel[rd_ptr];
      wen   = fifo_wen[rd_ptr];
      wdata = fifo_data[rd_ptr];
    end else if (bypass) begin
      wsel  = alu_wsel;
      wen   = alu_wen;
      wdata = alu_wdata;
    end
  end

  // Hazard bitmap covers queued entries and the in-flight gather target.
  always_comb begin
    busy_regs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i]) busy_regs[fifo_wsel[i]] = 1'b1;
    end
    if (ld_busy) busy_regs[ld_sel_q] = 1'b1;
    busy_regs[0] = 1'b0;
  end

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Directed bench for vector_writeback_unit with a write-port scoreboard.
// Honours VWB_BYPASS_EN for the ALU latency expectations.
`timescale 1ns/1ps
module tb_vector_writeback_unit;

  localparam int THREADS = 4;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             nRST;
  logic             alu_valid;
  logic             alu_ready;
  logic [4:0]       alu_wsel;
  logic [3:0]       alu_wen;
  logic [3:0][31:0] alu_wdata;
  logic             ld_start;
  logic [4:0]       ld_wsel;
  logic [3:0]       ld_mask;
  logic             ld_busy;
  logic             lane_valid;
  logic [1:0]       lane_id;
  logic [31:0]      lane_data;
  logic             wb_stall;
  logic [4:0]       wsel;
  logic [3:0]       wen;
  logic [3:0][31:0] wdata;
  logic [31:0]      busy_regs;
  logic             lane_err;

  typedef struct {
    logic [4:0]   wsel;
    logic [3:0]   wen;
    logic [127:0] data;
  } wb_t;

  wb_t sbQueue[$];
  int  checkCount = 0;
  int  passCount  = 0;
  int  failCount  = 0;

  always #5 clk = ~clk;

  vector_writeback_unit #(.THREADS(THREADS), .DEPTH(DEPTH)) dut (
    .clk(clk), .nRST(nRST),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wsel(alu_wsel),
    .alu_wen(alu_wen), .alu_wdata(alu_wdata),
    .ld_start(ld_start), .ld_wsel(ld_wsel), .ld_mask(ld_mask), .ld_busy(ld_busy),
    .lane_valid(lane_valid), .lane_id(lane_id), .lane_data(lane_data),
    .wb_stall(wb_stall), .wsel(wsel), .wen(wen), .wdata(wdata),
    .busy_regs(busy_regs), .lane_err(lane_err)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] laneMask(input logic [3:0] m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {32{m[i]}};
    return r;
  endfunction

  function automatic logic [127:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                       input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic sbPush(input logic [4:0] s, input logic [3:0] m, input logic [127:0] d);
    wb_t e;
    e.wsel = s;
    e.wen  = m;
    e.data = d;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] s, input logic [3:0] m,
                               input logic [127:0] d, input logic expectWrite);
    alu_valid = v;
    alu_wsel  = s;
    alu_wen   = m;
    alu_wdata = d;
    if (expectWrite) sbPush(s, m, d);
  endtask

  task automatic driveLane(input int id, input logic [31:0] d);
    lane_valid = 1'b1;
    lane_id    = 2'(id);
    lane_data  = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_alu_ready"}, alu_ready, 1);
    checkOutput({tag, "_ld_busy"}, ld_busy, 0);
    checkOutput({tag, "_busy_regs"}, busy_regs, 0);
    checkOutput({tag, "_lane_err"}, lane_err, 0);
    checkOutput({tag, "_wen"}, wen, 0);
    checkOutput({tag, "_wsel"}, wsel, 0);
    checkOutput({tag, "_wdata"}, wdata, 0);
  endtask

  // Scoreboard: every non-empty write-port cycle must match the oldest expected write.
  always @(negedge clk) begin
    wb_t e;
    if (nRST && wen != '0) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_write", {wsel, wen}, 0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("sb_wsel", wsel, e.wsel);
        checkOutput("sb_wen", wen, e.wen);
        checkOutput("sb_wdata", wdata & laneMask(e.wen), e.data & laneMask(e.wen));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nRST = 1'b0; alu_valid = 1'b0; alu_wsel = '0; alu_wen = '0; alu_wdata = '0;
    ld_start = 1'b0; ld_wsel = '0; ld_mask = '0;
    lane_valid = 1'b0; lane_id = '0; lane_data = '0; wb_stall = 1'b0;
    repeat (2) nextCycle();
    nRST = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset");

    // ALU write latency and busy bit lifetime
    nextCycle();
    applyStimulus(1'b1, 5'd5, 4'hF, vec(32'd1, 32'd2, 32'd3, 32'd4), 1'b1);
    @(negedge clk);
    checkOutput("t1_ready", alu_ready, 1);
`ifdef VWB_BYPASS_EN
    checkOutput("t1_bypass_wsel", wsel, 5);
    checkOutput("t1_bypass_busy5", busy_regs[5], 0);
`else
    checkOutput("t1_wen_early", wen, 0);
`endif
    nextCycle();
    applyStimulus(1'b0, 5'd0, 4'h0, '0, 1'b0);
    @(negedge clk);
`ifdef VWB_BYPASS_EN
    checkOutput("t1_wen_late", wen, 0);
`else
    checkOutput("t1_wsel", wsel, 5);
    checkOutput("t1_busy5", busy_regs[5], 1);
`endif
    nextCycle();
    @(negedge clk);
    checkOutput("t1_busy_clear", busy_regs, 0);
    checkOutput("t1_port_idle", wen, 0);

    // Load gather, lanes out of order
    nextCycle();
    ld_start = 1'b1; ld_wsel = 5'd9; ld_mask = 4'b1011;
    @(negedge clk);
    checkOutput("t2_busy_pre", ld_busy, 0);
    nextCycle();
    ld_start = 1'b0;
    driveLane(3, 32'hA0A0_0003);
    @(negedge clk);
    checkOutput("t2_ld_busy", ld_busy, 1);
    checkOutput("t2_busy9", busy_regs[9], 1);
    nextCycle();
    driveLane(0, 32'hB0B0_0000);
    nextCycle();
    driveLane(1, 32'hC0C0_0001);
    nextCycle();
    lane_valid = 1'b0;
    sbPush(5'd9, 4'b1011, vec(32'hB0B0_0000, 32'hC0C0_0001, 32'h0, 32'hA0A0_0003));
    @(negedge clk);
    checkOutput("t2_push_busy", ld_busy, 1);
    checkOutput("t2_push_ready", alu_ready, 0);
    checkOutput("t2_push_wen", wen, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_port_wsel", wsel, 9);
    checkOutput("t2_busy_done", ld_busy, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_drained", busy_regs, 0);
    checkOutput("t2_err", lane_err, 0);

    // Fill FIFO under stall, then drain in order
    nextCycle();
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 4'hF,
                    vec(32'h100 + i, 32'h200 + i, 32'h300 + i, 32'h400 + i), 1'b1);
      @(negedge clk);
      checkOutput($sformatf("t3_ready%0d", i), alu_ready, 1);
      nextCycle();
    end
    applyStimulus(1'b1, 5'd7, 4'hF, vec(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD), 1'b0);
    @(negedge clk);
    checkOutput("t3_full_ready", alu_ready, 0);
    checkOutput("t3_full_busy", busy_regs, 32'h0000_001E);
    checkOutput("t3_stalled_wen", wen, 0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 4'h0, '0, 1'b0);
    wb_stall = 1'b0;
    @(negedge clk);
    checkOutput("t3_ready_no_pop_credit", alu_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("t3_drain%0d", i), wsel, i);
      nextCycle();
      @(negedge clk);
    end
    checkOutput("t3_empty_wen", wen, 0);
    checkOutput("t3_empty_busy", busy_regs, 0);

    // Load PUSH collides with an ALU request
    nextCycle();
    ld_start = 1'b1; ld_wsel = 5'd10; ld_mask = 4'b0001;
    nextCycle();
    ld_start = 1'b0;
    driveLane(0, 32'hD0D0_0000);
    nextCycle();
    lane_valid = 1'b0;
    sbPush(5'd10, 4'b0001, vec(32'hD0D0_0000, 32'h0, 32'h0, 32'h0));
    applyStimulus(1'b1, 5'd11, 4'b0110, vec(32'h11, 32'h22, 32'h33, 32'h44), 1'b0);
    @(negedge clk);
    checkOutput("t4_ready_push", alu_ready, 0);
    checkOutput("t4_ld_busy", ld_busy, 1);
    nextCycle();
    sbPush(5'd11, 4'b0110, vec(32'h11, 32'h22, 32'h33, 32'h44));
    @(negedge clk);
    checkOutput("t4_ready_after", alu_ready, 1);
    checkOutput("t4_load_first", wsel, 10);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 4'h0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t4_alu_second", wsel, 11);

    // Duplicate lane sets sticky error, first beat kept
    nextCycle();
    ld_start = 1'b1; ld_wsel = 5'd12; ld_mask = 4'b0011;
    nextCycle();
    ld_start = 1'b0;
    driveLane(0, 32'hE0E0_0000);
    nextCycle();
    driveLane(0, 32'hF0F0_0000);
    @(negedge clk);
    checkOutput("t5_err_before", lane_err, 0);
    nextCycle();
    driveLane(1, 32'h6060_0001);
    @(negedge clk);
    checkOutput("t5_err_dup", lane_err, 1);
    nextCycle();
    lane_valid = 1'b0;
    sbPush(5'd12, 4'b0011, vec(32'hE0E0_0000, 32'h6060_0001, 32'h0, 32'h0));
    nextCycle();
    @(negedge clk);
    checkOutput("t5_port_wsel", wsel, 12);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_err_sticky", lane_err, 1);

    // Reset mid-gather with two queued entries: nothing may reach the port
    nextCycle();
    wb_stall = 1'b1;
    applyStimulus(1'b1, 5'd13, 4'hF, vec(32'h13, 32'h13, 32'h13, 32'h13), 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd14, 4'hF, vec(32'h14, 32'h14, 32'h14, 32'h14), 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 4'h0, '0, 1'b0);
    ld_start = 1'b1; ld_wsel = 5'd15; ld_mask = 4'hF;
    nextCycle();
    ld_start = 1'b0;
    driveLane(0, 32'h1515_0000);
    nextCycle();
    lane_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy_pre", busy_regs, 32'h0000_E000);
    nextCycle();
    nRST = 1'b0;
    nextCycle();
    nRST = 1'b1;
    wb_stall = 1'b0;
    @(negedge clk);
    checkResetOutputs("t6");
    nextCycle();
    driveLane(1, 32'h1515_0001);
    nextCycle();
    lane_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_err_idle_lane", lane_err, 1);
    checkOutput("t6_no_busy", ld_busy, 0);

    // Discarded requests complete the handshake but write nothing
    nextCycle();
    applyStimulus(1'b1, 5'd0, 4'hF, vec(32'h1, 32'h1, 32'h1, 32'h1), 1'b0);
    @(negedge clk);
    checkOutput("t7_ready_wsel0", alu_ready, 1);
    nextCycle();
    applyStimulus(1'b1, 5'd6, 4'h0, vec(32'h2, 32'h2, 32'h2, 32'h2), 1'b0);
    @(negedge clk);
    checkOutput("t7_ready_wen0", alu_ready, 1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 4'h0, '0, 1'b0);
    ld_start = 1'b1; ld_wsel = 5'd7; ld_mask = 4'h0;
    nextCycle();
    ld_wsel = 5'd0; ld_mask = 4'hF;
    @(negedge clk);
    checkOutput("t7_mask0_idle", ld_busy, 0);
    checkOutput("t7_busy_none", busy_regs, 0);
    nextCycle();
    ld_start = 1'b0;
    @(negedge clk);
    checkOutput("t7_wsel0_idle", ld_busy, 0);
    checkOutput("t7_no_write", wen, 0);

    // Lane outside the mask after a fresh reset
    nextCycle();
    nRST = 1'b0;
    nextCycle();
    nRST = 1'b1;
    @(negedge clk);
    checkOutput("t8_err_cleared", lane_err, 0);
    nextCycle();
    ld_start = 1'b1; ld_wsel = 5'd8; ld_mask = 4'b0101;
    nextCycle();
    ld_start = 1'b0;
    driveLane(1, 32'h9999_0001);
    nextCycle();
    driveLane(0, 32'h8080_0000);
    @(negedge clk);
    checkOutput("t8_err_outside", lane_err, 1);
    nextCycle();
    driveLane(2, 32'h8080_0002);
    nextCycle();
    lane_valid = 1'b0;
    sbPush(5'd8, 4'b0101, vec(32'h8080_0000, 32'h0, 32'h8080_0002, 32'h0));
    nextCycle();
    @(negedge clk);
    checkOutput("t8_port_wsel", wsel, 8);

    repeat (5) nextCycle();
    checkOutput("sb_all_drained", sbQueue.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
